// File: rtl/sym_sync_pkg.sv
// Shared constants and helpers for the symbol-timing interpolator.
// Holds default widths, mu constants, saturation and mu clamp.
package sym_sync_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEC_WIDTH_DEF  = 14;
  localparam int OUT_WIDTH_DEF  = 16;

  localparam int ONE        = 1 << DEC_WIDTH_DEF;
  localparam int ROUND_HALF = 1 << (DEC_WIDTH_DEF - 1);
  localparam int COEF_WIDTH = DATA_WIDTH_DEF + 2;

  // Clip a signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] sat_to_width(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

  // Restrict mu to [0, ONE-1] for a given number of fraction bits.
  function automatic logic signed [63:0] clamp_mu(
    input logic signed [63:0] u,
    input int                 dec
  );
    logic signed [63:0] one;
    one = 64'sd1 <<< dec;
    if (u < 64'sd0) begin
      return 64'sd0;
    end else if (u >= one) begin
      return one - 64'sd1;
    end else begin
      return u;
    end
  endfunction

endpackage

// File: rtl/farrow_interpolator_if.sv
// Sample/strobe input bundle and interpolated symbol output bundle.
// master: drives samples, mk, uk; slave: drives out_valid/out_i/out_q.
interface farrow_interpolator_if
  import sym_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
);

  logic                         data_ready;
  logic signed [DATA_WIDTH-1:0] in_i;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic                         mk;
  logic signed [DATA_WIDTH-1:0] uk;
  logic                         out_valid;
  logic signed [OUT_WIDTH-1:0]  out_i;
  logic signed [OUT_WIDTH-1:0]  out_q;

  modport master (
    output data_ready, in_i, in_q, mk, uk,
    input  out_valid, out_i, out_q
  );

  modport slave (
    input  data_ready, in_i, in_q, mk, uk,
    output out_valid, out_i, out_q
  );

endinterface

// File: rtl/farrow_channel.sv
// One channel: 4-tap line plus coefficient / Horner pipeline.
// Ports: clk, rst, shift_i, d_i, mu1_i, mu2_i, en_i -> y_o.
module farrow_channel
  import sym_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEC_WIDTH  = DEC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_i,
  input  logic signed [DATA_WIDTH-1:0] d_i,
  input  logic signed [DATA_WIDTH-1:0] mu1_i,
  input  logic signed [DATA_WIDTH-1:0] mu2_i,
  input  logic                         en_i,
  output logic signed [OUT_WIDTH-1:0]  y_o
);

  localparam int CW  = DATA_WIDTH + 2;
  localparam int XW  = CW + 1;
  localparam int TW  = CW + 2;
  localparam int P2W = CW + DATA_WIDTH;
  localparam int P3W = TW + DATA_WIDTH;
  localparam logic signed [P3W-1:0] RH =
    P3W'(1) <<< (DEC_WIDTH - 1);

  logic signed [DATA_WIDTH-1:0] tap_q [4];
  logic signed [DATA_WIDTH-1:0] tap_d [4];
  logic signed [CW-1:0]         c2_q, c2_d;
  logic signed [CW-1:0]         c1_q, c1_d;
  logic signed [DATA_WIDTH-1:0] c0_q, c0_d;
  logic signed [TW-1:0]         t_q, t_d;
  logic signed [TW-1:0]         c0e_q, c0e_d;
  logic signed [OUT_WIDTH-1:0]  y_q, y_d;

  logic signed [XW-1:0]  e0, e1, e2, e3;
  logic signed [XW-1:0]  s1, s2;
  logic signed [P2W-1:0] p2;
  logic signed [P3W-1:0] p3, y_w;
  logic signed [OUT_WIDTH-1:0] y_sat;

  always_comb begin
    tap_d = tap_q;
    if (shift_i) begin
      tap_d[0] = d_i;
      tap_d[1] = tap_q[0];
      tap_d[2] = tap_q[1];
      tap_d[3] = tap_q[2];
    end

    // E1: parabolic coefficients from the post-shift taps
    e0 = XW'(tap_q[0]);
    e1 = XW'(tap_q[1]);
    e2 = XW'(tap_q[2]);
    e3 = XW'(tap_q[3]);
    s2 = e0 - e1 - e2 + e3;
    s1 = (e1 <<< 1) + e1 - e0 - e2 - e3;
    c2_d = CW'(s2 >>> 1);
    c1_d = CW'(s1 >>> 1);
    c0_d = tap_q[2];

    // E2: inner Horner step, truncating
    p2    = P2W'(c2_q) * P2W'(mu1_i);
    t_d   = TW'(c1_q) + TW'(p2 >>> DEC_WIDTH);
    c0e_d = TW'(c0_q);

    // E3: outer Horner step, round half up
    p3    = P3W'(t_q) * P3W'(mu2_i) + RH;
    y_w   = P3W'(c0e_q) + (p3 >>> DEC_WIDTH);
    y_sat = OUT_WIDTH'(sat_to_width(64'(y_w), OUT_WIDTH));
    y_d   = en_i ? y_sat : y_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) tap_q[k] <= '0;
      c2_q  <= '0;
      c1_q  <= '0;
      c0_q  <= '0;
      t_q   <= '0;
      c0e_q <= '0;
      y_q   <= '0;
    end else begin
      tap_q <= tap_d;
      c2_q  <= c2_d;
      c1_q  <= c1_d;
      c0_q  <= c0_d;
      t_q   <= t_d;
      c0e_q <= c0e_d;
      y_q   <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/farrow_interpolator.sv
// Piecewise-parabolic Farrow interpolator, one I/Q symbol per strobe.
// Ports: clk, rst, bus (slave: samples/mk/uk in, out_valid/out_i/out_q).
module farrow_interpolator
  import sym_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEC_WIDTH  = DEC_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  farrow_interpolator_if.slave bus
);

  logic [2:0]                   fill_q, fill_d;
  logic                         stb;
  logic signed [DATA_WIDTH-1:0] mu0_q, mu0_d;
  logic signed [DATA_WIDTH-1:0] mu1_q, mu2_q;
  logic [2:0]                   vld_q;
  logic                         ov_q;

  always_comb begin
    // fill count before this sample; 3 means 4 taps valid after shift
    stb = bus.data_ready & bus.mk & (fill_q >= 3'd3);
    fill_d = fill_q;
    if (bus.data_ready && fill_q != 3'd4) begin
      fill_d = fill_q + 3'd1;
    end
    mu0_d = mu0_q;
    if (stb) begin
      mu0_d = DATA_WIDTH'(clamp_mu(64'(bus.uk), DEC_WIDTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      mu0_q  <= '0;
      mu1_q  <= '0;
      mu2_q  <= '0;
      vld_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      fill_q <= fill_d;
      mu0_q  <= mu0_d;
      mu1_q  <= mu0_q;
      mu2_q  <= mu1_q;
      vld_q  <= {vld_q[1:0], stb};
      ov_q   <= vld_q[2];
    end
  end

  farrow_channel #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEC_WIDTH (DEC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_ch_i (
    .clk    (clk),
    .rst    (rst),
    .shift_i(bus.data_ready),
    .d_i    (bus.in_i),
    .mu1_i  (mu1_q),
    .mu2_i  (mu2_q),
    .en_i   (vld_q[2]),
    .y_o    (bus.out_i)
  );

  farrow_channel #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEC_WIDTH (DEC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_ch_q (
    .clk    (clk),
    .rst    (rst),
    .shift_i(bus.data_ready),
    .d_i    (bus.in_q),
    .mu1_i  (mu1_q),
    .mu2_i  (mu2_q),
    .en_i   (vld_q[2]),
    .y_o    (bus.out_q)
  );

  assign bus.out_valid = ov_q;

endmodule

// File: tb/tb_farrow_interpolator.sv
// Directed bench for farrow_interpolator.
// Drives bus via the interface, checks hand-computed symbols.
module tb_farrow_interpolator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  farrow_interpolator_if bus ();

  farrow_interpolator dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(
    input logic dr,
    input int   i,
    input int   q,
    input logic m,
    input int   u
  );
    bus.data_ready = dr;
    bus.in_i       = 16'(i);
    bus.in_q       = 16'(q);
    bus.mk         = m;
    bus.uk         = 16'(u);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic chk(
    input string              tag,
    input logic signed [31:0] obs,
    input logic signed [31:0] want
  );
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, want);
    end
  endtask

  task automatic chk_out(
    input string tag,
    input int    v,
    input int    i,
    input int    q
  );
    chk({tag, "_v"}, 32'(bus.out_valid), v);
    chk({tag, "_i"}, 32'(bus.out_i), i);
    chk({tag, "_q"}, 32'(bus.out_q), q);
  endtask

  // four samples oldest first, strobe on the last, then wait 3 clocks
  task automatic feed4(
    input int i3, input int i2, input int i1, input int i0,
    input int q3, input int q2, input int q1, input int q0,
    input int u
  );
    step(1'b1, i3, q3, 1'b0, 0);
    step(1'b1, i2, q2, 1'b0, 0);
    step(1'b1, i1, q1, 1'b0, 0);
    step(1'b1, i0, q0, 1'b1, u);
    idle();
    chk("pipe_gap", 32'(bus.out_valid), 0);
    idle();
    idle();
  endtask

  int bu [5] = '{32'h0000, 32'h2000, 32'h1000, 32'h3FFF, 32'h7FFF};
  int ei [5] = '{10, 25, 33, 50, 60};
  int eq [5] = '{-10, -25, -32, -50, -60};
  logic seen;

  initial begin
    bus.data_ready = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.mk   = 1'b0;
    bus.uk   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;

    // ramp, strobes during fill must be dropped
    step(1'b1, 0, 0, 1'b1, 'h2000);
    chk("fill1", 32'(bus.out_valid), 0);
    step(1'b1, 100, 0, 1'b1, 'h2000);
    chk("fill2", 32'(bus.out_valid), 0);
    step(1'b1, 200, 0, 1'b1, 'h2000);
    chk("fill3", 32'(bus.out_valid), 0);
    step(1'b1, 300, 0, 1'b1, 'h2000);
    chk("fill4", 32'(bus.out_valid), 0);
    idle();
    chk("drop_a", 32'(bus.out_valid), 0);
    idle();
    chk("drop_b", 32'(bus.out_valid), 0);
    idle();
    chk_out("ramp", 1, 150, 0);
    idle();
    chk_out("hold", 0, 150, 0);

    // constant input, any mu gives the constant
    repeat (4) step(1'b1, 1000, 1000, 1'b0, 0);
    step(1'b1, 1000, 1000, 1'b1, 'h0000);
    step(1'b1, 1000, 1000, 1'b1, 'h1000);
    step(1'b1, 1000, 1000, 1'b1, 'h3FFF);
    idle();
    chk_out("const0", 1, 1000, 1000);
    idle();
    chk_out("const1", 1, 1000, 1000);
    idle();
    chk_out("const2", 1, 1000, 1000);

    // taps 7,5,3,1: endpoints and mu clamp
    feed4(1, 3, 5, 7, -1, -3, -5, -7, 'h0000);
    chk_out("mu0", 1, 3, -3);
    feed4(1, 3, 5, 7, -1, -3, -5, -7, -5);
    chk_out("mu_neg", 1, 3, -3);
    feed4(1, 3, 5, 7, -1, -3, -5, -7, 'h5000);
    chk_out("mu_big", 1, 5, -5);

    // overflow both ways must saturate
    feed4(-32768, 32767, 32767, -32768,
          32767, -32768, -32768, 32767, 'h2000);
    chk_out("sat", 1, 32767, -32768);

    // back-to-back strobes on a ramp of step 10
    step(1'b1, 0, 0, 1'b0, 0);
    step(1'b1, 10, -10, 1'b0, 0);
    step(1'b1, 20, -20, 1'b0, 0);
    for (int j = 0; j < 8; j++) begin
      if (j < 5) begin
        step(1'b1, 30 + 10 * j, -(30 + 10 * j), 1'b1, bu[j]);
      end else begin
        idle();
      end
      if (j >= 3) begin
        chk_out($sformatf("b2b%0d", j - 3), 1, ei[j - 3], eq[j - 3]);
      end
    end

    // async reset one clock after a strobe
    step(1'b1, 500, 500, 1'b1, 'h2000);
    idle();
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      idle();
      seen = seen | bus.out_valid;
    end
    chk("no_valid_after_rst", 32'(seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
